// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcode and
// funct values, ALU control codes and datapath mux selects.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   localparam logic [1:0] PC_SRC_ALU    = 2'd0;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
   localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

   localparam logic [1:0] SRCB_B       = 2'd0;
   localparam logic [1:0] SRCB_FOUR    = 2'd1;
   localparam logic [1:0] SRCB_IMM     = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

   // States whose exit back to FETCH completes an instruction.
   function automatic logic is_retiring(input state_e s);
      return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_ALUWB) ||
             (s == S_BRANCH) || (s == S_ADDIWB) || (s == S_JUMP);
   endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// R-type funct decoder: maps funct to an ALU control code and flags
// functs the datapath does not implement.
module mips_alu_decoder
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] funct,
   output logic [3:0] alu_ctrl,
   output logic       funct_legal
);

   // Pure lookup; unknown functs fall back to ADD and are flagged illegal.
   always_comb begin
      alu_ctrl    = ALU_ADD;
      funct_legal = 1'b1;
      case (funct)
         FN_ADD:  alu_ctrl = ALU_ADD;
         FN_SUB:  alu_ctrl = ALU_SUB;
         FN_AND:  alu_ctrl = ALU_AND;
         FN_OR:   alu_ctrl = ALU_OR;
         FN_SLT:  alu_ctrl = ALU_SLT;
         default: funct_legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS controller. Sequences a shared datapath through
// fetch/decode/execute/memory/writeback, stalling on the memory req/ready
// handshake, and counts retired instructions.
//
// Memory handshake: mem_req (with mem_we and iord) is raised in FETCH, MEMRD
// and MEMWR and held until the cycle mem_ready=1; that cycle completes the
// access and the FSM advances. mem_ready in any other state is ignored.
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int ALUOP_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               mem_req,
   output logic               mem_we,
   output logic               iord,
   output logic               ir_write,
   output logic               pc_write,
   output logic [1:0]         pc_src,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [ALUOP_W-1:0] alu_ctrl,
   output logic               reg_write,
   output logic               reg_dst,
   output logic               mem_to_reg,
   output logic               illegal,
   output logic [3:0]         state,
   output logic [CNT_W-1:0]   retired
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   retired_q, retired_d;
   logic [3:0]         dec_alu_ctrl;
   logic               funct_legal;
   logic [3:0]         alu_code;

   mips_alu_decoder u_alu_dec (
      .funct       (funct),
      .alu_ctrl    (dec_alu_ctrl),
      .funct_legal (funct_legal)
   );

   // State register and retired counter; reset returns to FETCH with count 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   // Next-state and Moore-style output decode; rst forces every output low
   // so an abandoned access never fires a strobe.
   always_comb begin
      state_d    = S_FETCH;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = PC_SRC_ALU;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_B;
      alu_code   = ALU_AND;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      illegal    = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = SRCB_FOUR;
            alu_code  = ALU_ADD;
            pc_src    = PC_SRC_ALU;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end else begin
               state_d  = S_FETCH;
            end
         end
         S_DECODE: begin
            // ALU precomputes PC+4 + (sext(imm)<<2) for a possible branch.
            alu_src_b = SRCB_IMM_SH2;
            alu_code  = ALU_ADD;
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE: begin
                  if (funct_legal) begin
                     state_d = S_EXEC;
                  end else begin
                     illegal = 1'b1;
                     state_d = S_FETCH;
                  end
               end
               OP_BEQ:  state_d = S_BRANCH;
               OP_ADDI: state_d = S_ADDIEX;
               OP_J:    state_d = S_JUMP;
               default: begin
                  illegal = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_code  = ALU_ADD;
            state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            state_d = mem_ready ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            iord    = 1'b1;
            state_d = mem_ready ? S_FETCH : S_MEMWR;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_B;
            alu_code  = dec_alu_ctrl;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            state_d   = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_B;
            alu_code  = ALU_SUB;
            pc_src    = PC_SRC_ALUOUT;
            pc_write  = zero;
            state_d   = S_FETCH;
         end
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_code  = ALU_ADD;
            state_d   = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_JUMP: begin
            pc_src   = PC_SRC_JUMP;
            pc_write = 1'b1;
            state_d  = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase

      if (rst) begin
         mem_req    = 1'b0;
         mem_we     = 1'b0;
         iord       = 1'b0;
         ir_write   = 1'b0;
         pc_write   = 1'b0;
         pc_src     = PC_SRC_ALU;
         alu_src_a  = 1'b0;
         alu_src_b  = SRCB_B;
         alu_code   = ALU_AND;
         reg_write  = 1'b0;
         reg_dst    = 1'b0;
         mem_to_reg = 1'b0;
         illegal    = 1'b0;
      end
   end

   // Count an instruction each time a completing state hands back to FETCH.
   always_comb begin
      retired_d = retired_q;
      if ((state_d == S_FETCH) && is_retiring(state_q)) begin
         retired_d = retired_q + CNT_W'(1);
      end
   end

   assign alu_ctrl = ALUOP_W'(alu_code);
   assign state    = rst ? 4'd0 : state_q;
   assign retired  = rst ? '0 : retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: an instruction-level model expands each
// instruction into its expected per-cycle output records; a negedge compare
// process checks every cycle against them.
module tb_mips_multicycle_ctrl;
   import mips_ctrl_pkg::*;

   typedef struct packed {
      logic [3:0]  st;
      logic        mem_req;
      logic        mem_we;
      logic        iord;
      logic        ir_write;
      logic        pc_write;
      logic [1:0]  pc_src;
      logic        alu_src_a;
      logic [1:0]  alu_src_b;
      logic [3:0]  alu_ctrl;
      logic        reg_write;
      logic        reg_dst;
      logic        mem_to_reg;
      logic        illegal;
      logic [31:0] retired;
   } rec_t;

   localparam int W = $bits(rec_t);

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  opcode, funct;
   logic        zero, mem_ready;
   logic        mem_req, mem_we, iord, ir_write, pc_write;
   logic [1:0]  pc_src, alu_src_b;
   logic        alu_src_a, reg_write, reg_dst, mem_to_reg, illegal;
   logic [3:0]  alu_ctrl, state;
   logic [31:0] retired;

   always #5 clk = ~clk;

   mips_multicycle_ctrl #(.CNT_W(32), .ALUOP_W(4)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .illegal(illegal), .state(state), .retired(retired)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   string        tag_q[$];
   int           n_cmp  = 0;
   int           n_fail = 0;
   int           cyc_no = 0;
   int           m_ret  = 0;

   // Every cycle with a queued expectation: compare all outputs at negedge.
   always @(negedge clk) begin
      rec_t  a, e;
      string t;
      cyc_no++;
      if (exp_q.size() > 0) begin
         e = rec_t'(exp_q.pop_front());
         t = tag_q.pop_front();
         a.st = state; a.mem_req = mem_req; a.mem_we = mem_we; a.iord = iord;
         a.ir_write = ir_write; a.pc_write = pc_write; a.pc_src = pc_src;
         a.alu_src_a = alu_src_a; a.alu_src_b = alu_src_b; a.alu_ctrl = alu_ctrl;
         a.reg_write = reg_write; a.reg_dst = reg_dst; a.mem_to_reg = mem_to_reg;
         a.illegal = illegal; a.retired = retired;
         n_cmp++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual st=%0d req=%b we=%b iord=%b irw=%b pcw=%b pcs=%0d sa=%b sb=%0d alu=%b rw=%b rd=%b m2r=%b ill=%b ret=%0d | required st=%0d req=%b we=%b iord=%b irw=%b pcw=%b pcs=%0d sa=%b sb=%0d alu=%b rw=%b rd=%b m2r=%b ill=%b ret=%0d",
               t, cyc_no, a.st, a.mem_req, a.mem_we, a.iord, a.ir_write, a.pc_write, a.pc_src,
               a.alu_src_a, a.alu_src_b, a.alu_ctrl, a.reg_write, a.reg_dst, a.mem_to_reg, a.illegal, a.retired,
               e.st, e.mem_req, e.mem_we, e.iord, e.ir_write, e.pc_write, e.pc_src,
               e.alu_src_a, e.alu_src_b, e.alu_ctrl, e.reg_write, e.reg_dst, e.mem_to_reg, e.illegal, e.retired);
         end
      end
   end

   task automatic chk(input string nm, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic rec_t base(input int st);
      rec_t r = '0;
      r.st      = 4'(st);
      r.retired = 32'(m_ret);
      return r;
   endfunction

   // ALU code demanded by an R-type funct; -1 means unsupported.
   function automatic int alu_of(input logic [5:0] fn);
      case (fn)
         6'h20: return 2;
         6'h22: return 6;
         6'h24: return 0;
         6'h25: return 1;
         6'h2A: return 7;
         default: return -1;
      endcase
   endfunction

   function automatic rec_t f_fetch(input logic rdy);
      rec_t r = base(0);
      r.mem_req = 1; r.alu_src_b = 1; r.alu_ctrl = 4'b0010;
      r.ir_write = rdy; r.pc_write = rdy;
      return r;
   endfunction

   function automatic rec_t f_decode(input logic ill);
      rec_t r = base(1);
      r.alu_src_b = 3; r.alu_ctrl = 4'b0010; r.illegal = ill;
      return r;
   endfunction

   function automatic rec_t f_alu_imm(input int st);
      rec_t r = base(st);
      r.alu_src_a = 1; r.alu_src_b = 2; r.alu_ctrl = 4'b0010;
      return r;
   endfunction

   function automatic rec_t f_mem(input int st, input logic we);
      rec_t r = base(st);
      r.mem_req = 1; r.iord = 1; r.mem_we = we;
      return r;
   endfunction

   function automatic rec_t f_wb(input int st, input logic rd, input logic m2r);
      rec_t r = base(st);
      r.reg_write = 1; r.reg_dst = rd; r.mem_to_reg = m2r;
      return r;
   endfunction

   function automatic rec_t f_exec(input int ac);
      rec_t r = base(6);
      r.alu_src_a = 1; r.alu_ctrl = 4'(ac);
      return r;
   endfunction

   function automatic rec_t f_branch(input logic z);
      rec_t r = base(8);
      r.alu_src_a = 1; r.alu_ctrl = 4'b0110; r.pc_src = 1; r.pc_write = z;
      return r;
   endfunction

   function automatic rec_t f_jump();
      rec_t r = base(11);
      r.pc_src = 2; r.pc_write = 1;
      return r;
   endfunction

   // ---------------- driver ----------------
   // One clock: apply inputs, queue this cycle's expectation, advance.
   task automatic step(input logic r, input logic rdy, input rec_t e, input string t);
      rst       = r;
      mem_ready = rdy;
      exp_q.push_back(W'(e));
      tag_q.push_back(t);
      @(posedge clk);
      #1;
   endtask

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   // Run one instruction: fw fetch stalls, mw data-memory stalls.
   task automatic do_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int fw, input int mw, input int exp_cyc);
      int   cyc = 0;
      int   ac;
      logic legal;
      opcode = op; funct = fn; zero = z;
      for (int i = 0; i < fw; i++) begin step(0, 0, f_fetch(0), {nm, ":fetch_wait"}); cyc++; end
      step(0, 1, f_fetch(1), {nm, ":fetch"}); cyc++;
      ac    = alu_of(fn);
      legal = (op == 6'h00) ? (ac >= 0) :
              (op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h08 || op == 6'h02);
      step(0, rnd(), f_decode(!legal), {nm, ":decode"}); cyc++;
      if (legal) begin
         if (op == 6'h00) begin
            step(0, rnd(), f_exec(ac), {nm, ":exec"}); cyc++;
            step(0, rnd(), f_wb(7, 1, 0), {nm, ":aluwb"}); cyc++;
         end else if (op == 6'h23 || op == 6'h2B) begin
            step(0, rnd(), f_alu_imm(2), {nm, ":memadr"}); cyc++;
            for (int i = 0; i < mw; i++) begin
               step(0, 0, f_mem(op == 6'h23 ? 3 : 5, op == 6'h2B), {nm, ":mem_wait"}); cyc++;
            end
            step(0, 1, f_mem(op == 6'h23 ? 3 : 5, op == 6'h2B), {nm, ":mem"}); cyc++;
            if (op == 6'h23) begin step(0, rnd(), f_wb(4, 0, 1), {nm, ":memwb"}); cyc++; end
         end else if (op == 6'h04) begin
            step(0, rnd(), f_branch(z), {nm, ":branch"}); cyc++;
         end else if (op == 6'h08) begin
            step(0, rnd(), f_alu_imm(9), {nm, ":addiex"}); cyc++;
            step(0, rnd(), f_wb(10, 0, 0), {nm, ":addiwb"}); cyc++;
         end else begin
            step(0, rnd(), f_jump(), {nm, ":jump"}); cyc++;
         end
         m_ret++;
      end
      chk({nm, " cycles"}, cyc, exp_cyc);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; mem_ready = 1'b0; opcode = 6'h00; funct = 6'h20; zero = 1'b0;
      @(posedge clk); #1;

      // Reset held two cycles: everything low.
      step(1, 0, '0, "reset0");
      step(1, 1, '0, "reset1");
      chk("reset mem_req", int'(mem_req), 0);
      chk("reset state", int'(state), 0);
      m_ret = 0;

      // Release with mem_ready=1: first FETCH loads IR/PC.
      rst = 1'b0; mem_ready = 1'b1; #2;
      chk("first fetch ir_write", int'(ir_write), 1);
      chk("first fetch pc_write", int'(pc_write), 1);
      chk("first fetch alu_src_b", int'(alu_src_b), 1);
      chk("first fetch alu_ctrl", int'(alu_ctrl), 2);

      do_instr("add", 6'h00, 6'h20, 0, 0, 0, 4);
      chk("retired after add", int'(retired), 1);

      do_instr("lw_stall", 6'h23, 6'h00, 0, 0, 3, 8);
      chk("retired after lw", int'(retired), 2);

      do_instr("beq_taken", 6'h04, 6'h11, 1, 0, 0, 3);
      do_instr("beq_not", 6'h04, 6'h11, 0, 0, 0, 3);
      chk("retired after beqs", int'(retired), 4);

      do_instr("bad_op", 6'h3F, 6'h20, 0, 0, 0, 2);
      do_instr("bad_funct", 6'h00, 6'h01, 0, 0, 0, 2);
      chk("retired after illegal", int'(retired), 4);

      do_instr("sub", 6'h00, 6'h22, 1, 0, 0, 4);
      do_instr("and", 6'h00, 6'h24, 0, 1, 0, 5);
      do_instr("or", 6'h00, 6'h25, 0, 0, 0, 4);
      do_instr("slt", 6'h00, 6'h2A, 0, 0, 0, 4);
      do_instr("addi", 6'h08, 6'h2A, 0, 0, 0, 4);
      do_instr("sw_stall", 6'h2B, 6'h00, 0, 0, 2, 6);
      do_instr("j_fetch_stall", 6'h02, 6'h00, 0, 2, 0, 5);
      chk("retired after mix", int'(retired), 11);

      // Reset while a store is stalled in MEMWR.
      opcode = 6'h2B; funct = 6'h00; zero = 1'b0;
      step(0, 1, f_fetch(1), "sw_abort:fetch");
      step(0, 0, f_decode(0), "sw_abort:decode");
      step(0, 0, f_alu_imm(2), "sw_abort:memadr");
      step(0, 0, f_mem(5, 1), "sw_abort:memwr");
      step(1, 0, '0, "sw_abort:rst");
      m_ret = 0;
      step(0, 0, f_fetch(0), "sw_abort:refetch");
      chk("retired after abort", int'(retired), 0);
      chk("state after abort", int'(state), 0);
      chk("mem_req after abort", int'(mem_req), 1);

      @(negedge clk); #1;
      chk("expect queue drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
